// File: rtl/ccff_chain_loader.sv
// Configuration-chain write driver: serializes host words MSB-first onto ccff_head, gating
// ccff_shift_en so exactly CHAIN_LEN bits enter the chain. Optional readback check: CCFF_CHAIN_VERIFY_EN.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 512,
   parameter int DATA_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int HW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [HW-1:0]     held_q, held_d;
   logic              head_q, head_d;

   logic          active, shift, xfer;
   logic [CW-1:0] cnt_after;

   assign active    = (state_q == LOAD) || (state_q == VERIFY);
   assign shift     = active && (held_q != '0) && (cnt_q != '0);
   assign cnt_after = shift ? cnt_q - CW'(1) : cnt_q;
   // Refill only when the register drains this cycle and the chain still wants more bits than it holds.
   assign data_ready = active && ((held_q == '0) || (held_q == HW'(1))) && (int'(cnt_q) > int'(held_q));
   assign xfer       = data_ready && data_valid;

   assign busy          = active;
   assign done          = (state_q == FIN);
   assign ccff_shift_en = shift;
   assign ccff_head     = shift ? sr_q[DATA_W-1] : head_q;

`ifdef CCFF_CHAIN_VERIFY_EN
   logic err_q, err_d;
   assign err = err_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      held_d  = held_q;
      head_d  = head_q;
`ifdef CCFF_CHAIN_VERIFY_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               cnt_d   = CW'(CHAIN_LEN);
               held_d  = '0;
`ifdef CCFF_CHAIN_VERIFY_EN
               err_d   = 1'b0;
`endif
            end
         end
         LOAD, VERIFY: begin
            if (shift) begin
               sr_d   = sr_q << 1;
               held_d = held_q - HW'(1);
               cnt_d  = cnt_q - CW'(1);
               head_d = sr_q[DATA_W-1];
`ifdef CCFF_CHAIN_VERIFY_EN
               if (state_q == VERIFY && ccff_tail != sr_q[DATA_W-1]) err_d = 1'b1;
`endif
            end
            // Final word: hold only the bits still owed; the low bits fall away.
            if (xfer) begin
               sr_d   = data_in;
               held_d = (int'(cnt_after) >= DATA_W) ? HW'(DATA_W) : HW'(cnt_after);
            end
            if (shift && cnt_q == CW'(1)) begin
               held_d = '0;
`ifdef CCFF_CHAIN_VERIFY_EN
               if (state_q == LOAD) begin
                  state_d = VERIFY;
                  cnt_d   = CW'(CHAIN_LEN);
               end else begin
                  state_d = FIN;
               end
`else
               state_d = FIN;
`endif
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         held_q  <= '0;
         head_q  <= 1'b0;
`ifdef CCFF_CHAIN_VERIFY_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         held_q  <= held_d;
         head_q  <= head_d;
`ifdef CCFF_CHAIN_VERIFY_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 10-bit chains, 8-bit words) driven
// with random words and host gaps, checked against a bit-list model and a behavioural chain.
module tb_ccff_chain_loader;

   logic       clk = 1'b0;
   logic [1:0] rst, start, valid;
   logic [7:0] din [2];
   wire  [1:0] ready, head, se, busy, done, err, tail;

   logic [15:0] ch0 = '0;
   logic [9:0]  ch1 = '0;

   int nchk = 0, nerr = 0;
   int nshift [2] = '{0, 0};
   int ndone  [2] = '{0, 0};
   int nbad   [2] = '{0, 0};
   int nxfer  [2] = '{0, 0};
   bit obsm [2][0:4095];
   logic [7:0] wq [0:1];

`ifdef CCFF_CHAIN_VERIFY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   always #5 clk = ~clk;

   ccff_chain_loader #(.CHAIN_LEN(16), .DATA_W(8)) u0 (
      .prog_clk(clk), .prog_reset(rst[0]), .start(start[0]), .data_in(din[0]),
      .data_valid(valid[0]), .data_ready(ready[0]), .ccff_head(head[0]),
      .ccff_shift_en(se[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   ccff_chain_loader #(.CHAIN_LEN(10), .DATA_W(8)) u1 (
      .prog_clk(clk), .prog_reset(rst[1]), .start(start[1]), .data_in(din[1]),
      .data_valid(valid[1]), .data_ready(ready[1]), .ccff_head(head[1]),
      .ccff_shift_en(se[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   // Behavioural chains: first bit shifted in ends up at the tail flop.
   always @(posedge clk) begin
      if (se[0]) ch0 <= {ch0[14:0], head[0]};
      if (se[1]) ch1 <= {ch1[8:0], head[1]};
   end
   assign tail = {ch1[9], ch0[15]};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (se[d]) begin
            if (nshift[d] < 4096) obsm[d][nshift[d]] = head[d];
            nshift[d]++;
         end
         if (done[d]) begin
            ndone[d]++;
            if (busy[d] || se[d]) nbad[d]++;
         end
         if (valid[d] && ready[d]) nxfer[d]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Model: the i-th chain bit of pass p is bit (7 - i%8) of word i/8, MSB first.
   function automatic bit mbit(input int i, input int p, input logic [7:0] flip);
      logic [7:0] w;
      w = wq[i/8];
      if (p == 1 && i/8 == 1) w = w ^ flip;
      return w[7 - i%8];
   endfunction

   task automatic run_load(input int d, input int gmin, input int gmax, input bit restart,
                           input bit extra, input logic [7:0] flip);
      int cl, nw, b_sh, b_dn, b_bad, b_x, k;
      logic [31:0] eo, ee;
      logic [7:0] w;
      bit got, experr;
      cl = (d == 0) ? 16 : 10;
      nw = (cl + 7) / 8;
      b_sh = nshift[d]; b_dn = ndone[d]; b_bad = nbad[d]; b_x = nxfer[d];
      @(negedge clk); start[d] = 1'b1;
      @(negedge clk); start[d] = 1'b0;
      chk("busy_after_start", busy[d], 1);
      chk("err_cleared", err[d], 0);
      for (int p = 0; p < PASSES; p++) begin
         for (int i = 0; i < nw; i++) begin
            k = $urandom_range(gmax, gmin);
            if (restart && p == 0 && i == 1 && k < 2) k = 2;
            for (int g = 0; g < k; g++) begin
               if (restart && p == 0 && i == 1 && g == 0) start[d] = 1'b1;
               @(negedge clk);
               start[d] = 1'b0;
            end
            w = wq[i];
            if (p == 1 && i == 1) w = w ^ flip;
            din[d] = w; valid[d] = 1'b1; got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
               if (ready[d]) got = 1;
               @(negedge clk);
            end
            valid[d] = 1'b0;
            if (!got) chk("ready_timeout", 0, 1);
         end
      end
      if (extra) begin din[d] = 8'h77; valid[d] = 1'b1; end
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(posedge clk); #1;
         if (ndone[d] != b_dn) got = 1;
      end
      if (!got) chk("done_timeout", 0, 1);
      @(negedge clk); valid[d] = 1'b0;
      chk("shift_count", nshift[d] - b_sh, cl * PASSES);
      chk("done_pulses", ndone[d] - b_dn, 1);
      chk("done_busy_se_low", nbad[d] - b_bad, 0);
      chk("word_xfers", nxfer[d] - b_x, nw * PASSES);
      chk("busy_end", busy[d], 0);
      ee = '0; eo = '0; experr = 0;
      for (int i = 0; i < cl; i++) begin
         ee = {ee[30:0], 1'(mbit(i, 0, flip))};
         eo = {eo[30:0], 1'(obsm[d][(b_sh + i) % 4096])};
`ifdef CCFF_CHAIN_VERIFY_EN
         if (mbit(i, 0, flip) != mbit(i, 1, flip)) experr = 1;
`endif
      end
      chk("head_seq", eo, ee);
      chk("err_flag", err[d], experr);
   endtask

   initial begin
      int b;
      bit got;
      rst = 2'b11; start = '0; valid = '0; din[0] = '0; din[1] = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs_d0", {busy[0], ready[0], se[0], done[0], err[0], head[0]}, 0);
      chk("reset_outs_d1", {busy[1], ready[1], se[1], done[1], err[1], head[1]}, 0);
      rst = 2'b00;
      @(negedge clk);

      wq[0] = 8'hA5; wq[1] = 8'h3C;
      run_load(0, 0, 0, 0, 0, 8'h00);
      wq[0] = 8'hFF; wq[1] = 8'hC0;
      run_load(1, 0, 0, 0, 1, 8'h00);
      wq[0] = 8'h5A; wq[1] = 8'hE1;
      run_load(0, 5, 5, 0, 0, 8'h00);

      // Reset after 7 bits have entered the chain.
      wq[0] = 8'hA5; wq[1] = 8'h3C;
      b = nshift[0];
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0; din[0] = 8'hA5; valid[0] = 1'b1;
      got = 0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(posedge clk); #1;
         if (nshift[0] - b >= 7) got = 1;
      end
      if (!got) chk("mid_timeout", 0, 1);
      rst[0] = 1'b1; #1;
      chk("reset_mid_load", {busy[0], ready[0], se[0], done[0]}, 0);
      valid[0] = 1'b0;
      @(negedge clk); rst[0] = 1'b0;
      run_load(0, 0, 1, 0, 0, 8'h00);

`ifdef CCFF_CHAIN_VERIFY_EN
      wq[0] = 8'h96; wq[1] = 8'h0F;
      run_load(0, 0, 0, 0, 0, 8'h00);
      run_load(0, 0, 0, 0, 0, 8'h10);
      run_load(0, 0, 0, 0, 0, 8'h00);
`endif

      wq[0] = 8'h3B; wq[1] = 8'hD2;
      run_load(0, 1, 3, 1, 0, 8'h00);
      run_load(1, 1, 3, 1, 0, 8'h00);

      for (int it = 0; it < 10; it++) begin
         logic [7:0] fl;
         wq[0] = 8'($urandom); wq[1] = 8'($urandom);
         fl = 8'h00;
`ifdef CCFF_CHAIN_VERIFY_EN
         if ($urandom_range(1, 0) == 1) fl = 8'($urandom);
`endif
         run_load(int'($urandom_range(1, 0)), 0, int'($urandom_range(3, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), fl);
      end

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
